// File: rtl/issue_sched_pkg.sv
// Shared unit IDs and default latencies for the issue scheduler,
// the CDB writeback mux and the issue queues.
package issue_sched_pkg;

    localparam logic [1:0] UNIT_INT  = 2'd0;
    localparam logic [1:0] UNIT_LS   = 2'd1;
    localparam logic [1:0] UNIT_MULT = 2'd2;
    localparam logic [1:0] UNIT_DIV  = 2'd3;

    localparam int DEF_INT_LAT  = 1;
    localparam int DEF_LS_LAT   = 1;
    localparam int DEF_MULT_LAT = 4;
    localparam int DEF_DIV_LAT  = 6;

    function automatic int max4(
        input int a,
        input int b,
        input int c,
        input int d
    );
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/cdb_rsv_shreg.sv
// CDB reservation shift register: slot i set means the CDB is
// claimed i cycles from now, with the owning unit alongside.
module cdb_rsv_shreg #(
    parameter int MAX_LAT = 6,
    parameter int LAT_W   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               claim_en,
    input  logic [LAT_W-1:0]   claim_lat,
    input  logic [1:0]         claim_id,
    output logic [MAX_LAT:0]   rsv,
    output logic [1:0]         owner0
);

    logic [MAX_LAT:0] rsv_q;
    logic [MAX_LAT:0] rsv_d;
    logic [1:0]       own_q [MAX_LAT+1];
    logic [1:0]       own_d [MAX_LAT+1];

    // A claim of latency L lands at post-shift index L-1.
    always_comb begin
        rsv_d = '0;
        for (int i = 0; i <= MAX_LAT; i++) begin
            own_d[i] = 2'd0;
        end
        for (int i = 0; i < MAX_LAT; i++) begin
            if (claim_en && claim_lat == LAT_W'(i + 1)) begin
                rsv_d[i] = 1'b1;
                own_d[i] = claim_id;
            end else begin
                rsv_d[i] = rsv_q[i+1];
                own_d[i] = own_q[i+1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsv_q <= '0;
            for (int i = 0; i <= MAX_LAT; i++) begin
                own_q[i] <= 2'd0;
            end
        end else begin
            rsv_q <= rsv_d;
            for (int i = 0; i <= MAX_LAT; i++) begin
                own_q[i] <= own_d[i];
            end
        end
    end

    assign rsv    = rsv_q;
    assign owner0 = own_q[0];

endmodule

// File: rtl/issue_sched.sv
// Single-issue round-robin scheduler over the int/ls/mult/div queues,
// with CDB slot reservation so no two units write back together.
module issue_sched
    import issue_sched_pkg::*;
#(
    parameter int INT_LAT  = DEF_INT_LAT,
    parameter int LS_LAT   = DEF_LS_LAT,
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issueint_ready,
    input  logic       issuels_ready,
    input  logic       issuemult_ready,
    input  logic       issuediv_ready,
    output logic       issueint_done,
    output logic       issuels_done,
    output logic       issuemult_done,
    output logic       issuediv_done,
    output logic [1:0] cdb_sel,
    output logic       cdb_sel_valid
);

    localparam int MAX_LAT = max4(INT_LAT, LS_LAT, MULT_LAT, DIV_LAT);
    localparam int LAT_W   = $clog2(MAX_LAT + 1);
    localparam int DCNT_W  = $clog2(DIV_LAT + 1);

    localparam logic [LAT_W-1:0] LAT [4] = '{
        LAT_W'(INT_LAT),
        LAT_W'(LS_LAT),
        LAT_W'(MULT_LAT),
        LAT_W'(DIV_LAT)
    };

    logic [MAX_LAT:0]  rsv;
    logic [1:0]        owner0;
    logic [1:0]        rr_ptr;
    logic [DCNT_W-1:0] div_cnt;
    logic [3:0]        rdy;
    logic [3:0]        elig;
    logic [3:0]        gnt;
    logic              gnt_en;
    logic              found;
    logic [1:0]        gnt_id;
    logic [1:0]        idx;

    assign rdy = {issuediv_ready, issuemult_ready,
                  issuels_ready, issueint_ready};

    // A unit may issue only if its writeback slot is still free.
    always_comb begin
        for (int u = 0; u < 4; u++) begin
            elig[u] = rdy[u] & ~rsv[LAT[u]];
        end
        elig[UNIT_DIV] = elig[UNIT_DIV] & (div_cnt == '0);
    end

    always_comb begin
        found  = 1'b0;
        gnt_id = rr_ptr;
        idx    = rr_ptr;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (!found && elig[idx]) begin
                found  = 1'b1;
                gnt_id = idx;
            end
        end
        gnt_en = found & ~reset;
    end

    always_comb begin
        gnt = 4'b0000;
        unique case (1'b1)
            (gnt_en && gnt_id == UNIT_INT):  gnt = 4'b0001;
            (gnt_en && gnt_id == UNIT_LS):   gnt = 4'b0010;
            (gnt_en && gnt_id == UNIT_MULT): gnt = 4'b0100;
            (gnt_en && gnt_id == UNIT_DIV):  gnt = 4'b1000;
            default:                         gnt = 4'b0000;
        endcase
    end

    assign issueint_done  = gnt[UNIT_INT];
    assign issuels_done   = gnt[UNIT_LS];
    assign issuemult_done = gnt[UNIT_MULT];
    assign issuediv_done  = gnt[UNIT_DIV];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= 2'd0;
        end else if (gnt_en) begin
            rr_ptr <= gnt_id + 2'd1;
        end
    end

    // Divider is not pipelined: block re-issue for DIV_LAT cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (gnt_en && gnt_id == UNIT_DIV) begin
            div_cnt <= DCNT_W'(DIV_LAT - 1);
        end else if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

    cdb_rsv_shreg #(
        .MAX_LAT (MAX_LAT),
        .LAT_W   (LAT_W)
    ) u_rsv (
        .clk       (clk),
        .reset     (reset),
        .claim_en  (gnt_en),
        .claim_lat (LAT[gnt_id]),
        .claim_id  (gnt_id),
        .rsv       (rsv),
        .owner0    (owner0)
    );

    assign cdb_sel_valid = rsv[0];
    assign cdb_sel       = owner0;

endmodule

// File: tb/tb_issue_sched.sv
// Bench for issue_sched: cycle-level model of future CDB writebacks
// keyed by absolute cycle, plus directed literal expectations.
module tb_issue_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       int_r = 1'b0;
    logic       ls_r = 1'b0;
    logic       mult_r = 1'b0;
    logic       div_r = 1'b0;
    logic       int_d;
    logic       ls_d;
    logic       mult_d;
    logic       div_d;
    logic [1:0] cdb_sel;
    logic       cdb_sel_valid;

    int checks = 0;
    int errors = 0;

    int lat_tab [4] = '{1, 1, 4, 6};

    int wb [int];
    int rr = 0;
    int div_free = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    issue_sched dut (
        .clk             (clk),
        .reset           (reset),
        .issueint_ready  (int_r),
        .issuels_ready   (ls_r),
        .issuemult_ready (mult_r),
        .issuediv_ready  (div_r),
        .issueint_done   (int_d),
        .issuels_done    (ls_d),
        .issuemult_done  (mult_d),
        .issuediv_done   (div_d),
        .cdb_sel         (cdb_sel),
        .cdb_sel_valid   (cdb_sel_valid)
    );

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int dut_vec();
        return {28'd0, div_d, mult_d, ls_d, int_d};
    endfunction

    // Model: each negedge judges the cycle, then advances to the next edge.
    always @(negedge clk) begin : model
        int rdy [4];
        int exp_g;
        int u;
        int dv;
        dv = dut_vec();
        if (reset) begin
            check("rst_done", dv, 0);
            check("rst_valid", int'(cdb_sel_valid), 0);
            check("rst_sel", int'(cdb_sel), 0);
            wb.delete();
            rr = 0;
            div_free = 0;
        end else begin
            rdy[0] = int'(int_r);
            rdy[1] = int'(ls_r);
            rdy[2] = int'(mult_r);
            rdy[3] = int'(div_r);
            exp_g = -1;
            for (int k = 0; k < 4; k++) begin
                u = (rr + k) % 4;
                if (exp_g < 0 && rdy[u] != 0 && !wb.exists(cyc + lat_tab[u])
                    && (u != 3 || cyc >= div_free))
                    exp_g = u;
            end
            check("grant", dv, exp_g < 0 ? 0 : (1 << exp_g));
            check("onehot0", int'($onehot0(dv[3:0])), 1);
            for (int g = 0; g < 4; g++) begin
                if (dv[g])
                    check("slot_free", int'(wb.exists(cyc + lat_tab[g])), 0);
            end
            check("cdb_valid", int'(cdb_sel_valid), int'(wb.exists(cyc)));
            if (wb.exists(cyc))
                check("cdb_sel", int'(cdb_sel), wb[cyc]);
            wb.delete(cyc);
            if (exp_g >= 0) begin
                wb[cyc + lat_tab[exp_g]] = exp_g;
                rr = (exp_g + 1) % 4;
                if (exp_g == 3)
                    div_free = cyc + 6;
            end
        end
        cyc++;
    end

    // r = {div, mult, ls, int}; leaves time at posedge+3 for literal checks.
    task automatic apply(input logic [3:0] r);
        @(posedge clk);
        #1;
        {div_r, mult_r, ls_r, int_r} = r;
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        {div_r, mult_r, ls_r, int_r} = 4'b0000;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // Reset with every queue ready: nothing may be granted.
        {div_r, mult_r, ls_r, int_r} = 4'b1111;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("lit_rst_done", dut_vec(), 0);
        check("lit_rst_valid", int'(cdb_sel_valid), 0);
        reset = 1'b0;
        #2;
        check("lit_first_int", dut_vec(), 1);
        apply(4'b0000);
        check("lit_first_valid", int'(cdb_sel_valid), 1);
        check("lit_first_sel", int'(cdb_sel), 0);

        // Multiply holds slot, int blocked one cycle then issues.
        do_reset();
        apply(4'b0100);
        check("lit_mult_gnt", int'(mult_d), 1);
        apply(4'b0000);
        apply(4'b0000);
        apply(4'b0001);
        check("lit_int_blocked", int'(int_d), 0);
        apply(4'b0001);
        check("lit_int_late", int'(int_d), 1);
        check("lit_mult_wb", int'(cdb_sel), 2);
        apply(4'b0000);
        check("lit_int_wb_v", int'(cdb_sel_valid), 1);
        check("lit_int_wb", int'(cdb_sel), 0);

        // Divider held ready: one issue every six cycles.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            apply(4'b1000);
            if (i == 0 || i == 6 || i == 12)
                check("lit_div_pulse", int'(div_d), 1);
            if (i == 1 || i == 5)
                check("lit_div_busy", int'(div_d), 0);
            if (i == 6 || i == 12 || i == 18)
                check("lit_div_wb", int'(cdb_sel_valid && cdb_sel == 2'd3), 1);
        end

        // Int and ls alternate under round-robin.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(4'b0011);
            check("lit_alt", dut_vec(), (i % 2 == 0) ? 1 : 2);
        end
        for (int i = 0; i < 3; i++) apply(4'b0000);

        // rr_ptr at 3: div beats mult, mult follows next cycle.
        do_reset();
        apply(4'b0100);
        apply(4'b1100);
        check("lit_div_first", dut_vec(), 8);
        apply(4'b0100);
        check("lit_mult_next", dut_vec(), 4);
        for (int i = 0; i < 8; i++) apply(4'b0000);

        // Reset with in-flight reservations discards them at once.
        do_reset();
        apply(4'b0001);
        apply(4'b0100);
        apply(4'b0010);
        apply(4'b0000);
        check("lit_pre_rst_v", int'(cdb_sel_valid), 1);
        check("lit_pre_rst_sel", int'(cdb_sel), 1);
        reset = 1'b1;
        #1;
        check("lit_async_v", int'(cdb_sel_valid), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            apply(4'b0000);
            check("lit_no_stale", int'(cdb_sel_valid), 0);
        end

        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
